output_backprop_seq: RTL and testbench

Controller that sequences the output-layer weight-update datapath (output_backprop) across all hidden-to-output weights in one backprop pass. It fetches each weight and its hidden activation, fires the datapath once, waits for its update-valid flag, and writes the updated weight back to the weight store. It sits between the top-level state machine, which issues start/done, and the weight/hidden register files.

---
 rtl/bp_pkg.sv | 12 +
 rtl/bp_timeout_ctr.sv | 27 ++
 rtl/output_backprop_seq.sv | 134 +++++++++++++
 tb/tb_output_backprop_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and widths for the output-layer backprop sequencer.
package bp_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_FIRE, S_WAIT, S_WRITE, S_DONE
  } state_e;

  localparam int WEIGHT_W     = 8;
  localparam int HID_W        = 10;
  localparam int X_W          = 4;
  localparam int FINAL_W      = 19;
  localparam int N_HIDDEN_DEF = 4;
endpackage

// File: rtl/bp_timeout_ctr.sv
// Wait-cycle counter for the datapath handshake; saturates at TIMEOUT.
module bp_timeout_ctr #(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/output_backprop_seq.sv
// Walks every hidden-to-output weight: read, fire datapath, wait for valid,
// write back. Aborts the pass on a datapath timeout.
module output_backprop_seq
  import bp_pkg::*;
#(
  parameter int N_HIDDEN = N_HIDDEN_DEF,
  parameter int IDX_W    = 2,
  parameter int TIMEOUT  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [X_W-1:0]      target_i,
  input  logic [FINAL_W-1:0]  final_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [IDX_W-1:0]    idx_o,
  input  logic [WEIGHT_W-1:0] w_rd_i,
  input  logic [HID_W-1:0]    hid_rd_i,
  output logic                w_wr_en_o,
  output logic [WEIGHT_W-1:0] w_wr_data_o,
  output logic                dp_en_o,
  output logic                dp_clr_o,
  output logic [X_W-1:0]      dp_x_o,
  output logic [FINAL_W-1:0]  dp_final_o,
  output logic [HID_W-1:0]    dp_hidden_o,
  output logic [WEIGHT_W-1:0] dp_w_o,
  input  logic [WEIGHT_W-1:0] dp_w_i,
  input  logic                dp_valid_i
);
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [FINAL_W-1:0]  fin_q, fin_d;
  logic [WEIGHT_W-1:0] w_q, w_d;
  logic [HID_W-1:0]    hid_q, hid_d;
  logic [WEIGHT_W-1:0] upd_q, upd_d;
  logic                expired;
  logic                act;

  bp_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == S_FIRE),
    .en_i      ((state_q == S_WAIT) && !dp_valid_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    x_d     = x_q;
    fin_d   = fin_q;
    w_d     = w_q;
    hid_d   = hid_q;
    upd_d   = upd_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        x_d     = target_i;
        fin_d   = final_i;
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_CLR;
      end
      S_CLR:  state_d = S_READ;
      S_READ: state_d = S_FIRE;
      S_FIRE: begin
        w_d     = w_rd_i;
        hid_d   = hid_rd_i;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dp_valid_i) begin
          upd_d   = dp_w_i;
          state_d = S_WRITE;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (idx_q == IDX_W'(N_HIDDEN - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CLR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      x_q     <= '0;
      fin_q   <= '0;
      w_q     <= '0;
      hid_q   <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      x_q     <= x_d;
      fin_q   <= fin_d;
      w_q     <= w_d;
      hid_q   <= hid_d;
      upd_q   <= upd_d;
    end
  end

  // Outputs are forced low while rst_i is high so an in-flight write is dropped.
  assign act         = !rst_i;
  assign busy_o      = act && (state_q != S_IDLE);
  assign done_o      = act && (state_q == S_DONE);
  assign err_o       = act && err_q;
  assign idx_o       = act ? idx_q : '0;
  assign w_wr_en_o   = act && (state_q == S_WRITE);
  assign w_wr_data_o = act ? upd_q : '0;
  assign dp_en_o     = act && (state_q == S_FIRE);
  assign dp_clr_o    = act && (state_q == S_CLR);
  assign dp_x_o      = act ? x_q : '0;
  assign dp_final_o  = act ? fin_q : '0;
  // Read data is live in FIRE so the datapath sees it on the same edge as dp_en_o.
  assign dp_w_o      = !act ? '0 : (state_q == S_FIRE) ? w_rd_i : w_q;
  assign dp_hidden_o = !act ? '0 : (state_q == S_FIRE) ? hid_rd_i : hid_q;
endmodule

// File: tb/tb_output_backprop_seq.sv
// Scoreboard bench for output_backprop_seq with register-file and datapath models.
module tb_output_backprop_seq;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  target_i = '0;
  logic [18:0] final_i = '0;
  logic        busy_o, done_o, err_o;
  logic [1:0]  idx_o;
  logic [7:0]  w_rd_i = '0;
  logic [9:0]  hid_rd_i = '0;
  logic        w_wr_en_o;
  logic [7:0]  w_wr_data_o;
  logic        dp_en_o, dp_clr_o;
  logic [3:0]  dp_x_o;
  logic [18:0] dp_final_o;
  logic [9:0]  dp_hidden_o;
  logic [7:0]  dp_w_o;
  logic [7:0]  dp_w_i = '0;
  logic        dp_valid_i = 1'b0;

  output_backprop_seq #(.N_HIDDEN(4), .IDX_W(2), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .target_i(target_i),
    .final_i(final_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .idx_o(idx_o), .w_rd_i(w_rd_i), .hid_rd_i(hid_rd_i),
    .w_wr_en_o(w_wr_en_o), .w_wr_data_o(w_wr_data_o), .dp_en_o(dp_en_o),
    .dp_clr_o(dp_clr_o), .dp_x_o(dp_x_o), .dp_final_o(dp_final_o),
    .dp_hidden_o(dp_hidden_o), .dp_w_o(dp_w_o), .dp_w_i(dp_w_i),
    .dp_valid_i(dp_valid_i)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int data; int cyc; } wr_t;
  typedef struct { int cyc; int err; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, base = 0, lat = 1, pend = 0, fire_k = 0;
  logic [7:0] wmem [4];
  logic [9:0] hmem [4];
  logic       latch_on = 1'b0;
  logic [3:0] exp_x = '0;
  logic [18:0] exp_f = '0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc - base);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // registered-read register files and a datapath returning w+1 after lat cycles
  always @(posedge clk) begin
    w_rd_i   <= wmem[idx_o];
    hid_rd_i <= hmem[idx_o];
    if (rst_i || dp_clr_o) begin
      dp_valid_i <= 1'b0;
      pend       <= 0;
    end else if (dp_en_o) begin
      dp_w_i <= dp_w_o + 8'd1;
      if (lat == 1) dp_valid_i <= 1'b1;
      else if (lat > 1) pend <= lat - 1;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) dp_valid_i <= 1'b1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (!busy_o) fire_k = 0;
    if (w_wr_en_o) begin
      if (wr_q.size() == 0) chk("wr_unexp", 1, 0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_idx", idx_o, e.idx);
        chk("wr_data", w_wr_data_o, e.data);
        chk("wr_cyc", cyc - base, e.cyc);
      end
    end
    if (done_o) begin
      if (dn_q.size() == 0) chk("done_unexp", 1, 0);
      else begin
        dn_t d;
        d = dn_q.pop_front();
        chk("done_cyc", cyc - base, d.cyc);
        chk("done_err", err_o, d.err);
      end
    end
    if (dp_en_o && fire_k < 4) begin
      chk("dp_w", dp_w_o, wmem[fire_k]);
      chk("dp_hid", dp_hidden_o, hmem[fire_k]);
      fire_k++;
    end
    if (latch_on && busy_o) begin
      chk("dp_x", dp_x_o, exp_x);
      chk("dp_final", dp_final_o, exp_f);
    end
  end

  task automatic start_pass(input int l, input logic [3:0] t, input logic [18:0] f);
    @(negedge clk);
    lat = l; target_i = t; final_i = f; start_i = 1'b1; base = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  task automatic load_mem(input int w0);
    for (int k = 0; k < 4; k++) begin
      wmem[k] = 8'(w0 * (k + 1));
      hmem[k] = 10'(300 + 7 * k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    load_mem(10);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_idx", idx_o, 0);
    rst_i = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_x", dp_x_o, 0);

    // nominal pass with mid-pass input changes
    for (int k = 0; k < 4; k++) wr_q.push_back('{k, 10 * (k + 1) + 1, 5 + 5 * k});
    dn_q.push_back('{21, 0});
    exp_x = 4'd5; exp_f = 19'd100; latch_on = 1'b1;
    start_pass(1, 4'd5, 19'd100);
    wait_rel(2);
    target_i = 4'd9; final_i = 19'd7;
    wait_rel(25);
    latch_on = 1'b0;
    chk("nom_busy_end", busy_o, 0);

    // timeout: datapath never answers
    load_mem(3);
    dn_q.push_back('{13, 1});
    start_pass(0, 4'd1, 19'd1);
    wait_rel(14); #1;
    chk("tmo_err_sticky", err_o, 1);
    wait_rel(18);

    // start pulses at 0, 3 and 21; only the first is accepted
    for (int k = 0; k < 4; k++) wr_q.push_back('{k, 3 * (k + 1) + 1, 5 + 5 * k});
    dn_q.push_back('{21, 0});
    start_pass(1, 4'd2, 19'd2);
    #1;
    chk("err_cleared", err_o, 0);
    wait_rel(3);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_rel(21);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    #1;
    chk("busy_c22", busy_o, 0);
    wait_rel(24); #1;
    chk("busy_c24", busy_o, 0);

    // slow datapath: valid arrives 3 cycles after fire
    load_mem(20);
    for (int k = 0; k < 4; k++) wr_q.push_back('{k, 20 * (k + 1) + 1, 7 + 7 * k});
    dn_q.push_back('{29, 0});
    start_pass(3, 4'd3, 19'd3);
    wait_rel(33); #1;
    chk("slow_err", err_o, 0);

    // reset during WRITE of idx1
    load_mem(5);
    wr_q.push_back('{0, 6, 5});
    start_pass(1, 4'd7, 19'd77);
    wait_rel(10);
    rst_i = 1'b1; #1;
    chk("rst_wr_en", w_wr_en_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_x", dp_x_o, 0);
    @(negedge clk);
    rst_i = 1'b0; #1;
    chk("c11_busy", busy_o, 0);
    chk("c11_w", dp_w_o, 0);
    chk("c11_final", dp_final_o, 0);
    chk("c11_idx", idx_o, 0);
    wait_rel(40);

    chk("wr_q_left", wr_q.size(), 0);
    chk("dn_q_left", dn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
